ex_mem_pipe_reg: RTL and testbench
==================================

Name: ex_mem_pipe_reg

Overview:
Parametrised EX/MEM pipeline register. It replaces the fixed-width, always-enabled EX/MEM latch with a valid/ready handshake, a 2-entry skid buffer, a synchronous flush and a forwarding tap.
It sits between the execute stage and the memory stage. It absorbs memory-stage back-pressure without a combinational ready path, and it feeds the forwarding unit.

Parameters:
DATA_W, 32, width of ALU result, branch target and store data
REG_AW, 5, destination register index width
CTRL_W, 6, control bundle width (bit map in package)

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous active-high reset
flush  in  1  synchronous kill of all held entries (branch/jump taken)
in_valid  in  1  EX stage presents an entry
in_ready  out  1  stage can accept; driven from a register, no combinational path from out_ready
alu_in  in  DATA_W  ALU result
zero_in  in  1  ALU zero flag
addr_in  in  DATA_W  branch target adder result
rdata2_in  in  DATA_W  rt read data (store data)
dst_in  in  REG_AW  destination register (rt/rd selected)
ctrl_in  in  CTRL_W  control bundle
out_valid  out  1  MEM stage entry valid
out_ready  in  1  MEM stage accepts
alu_out, zero_out, addr_out, rdata2_out, dst_out, ctrl_out  out  as inputs  registered payload
fwd_en  out  1  out_valid & ctrl_out[REGWRITE] & (dst_out != 0)
fwd_dst  out  REG_AW  equals dst_out
fwd_data  out  DATA_W  equals alu_out

Behaviour:
- Storage: main register M (drives outputs) and skid register S; each has a valid bit.
- Reset (async): M.valid=0, S.valid=0, all payload and ctrl=0, in_ready=1. Therefore out_valid=0, fwd_en=0 and all outputs are 0 while rst is high and after it is released.
- Accept: in_accept = in_valid & in_ready. Drain: out_fire = out_valid & out_ready.
- Latency: 1 cycle. An entry accepted at edge N appears at the outputs after edge N when M is empty or draining.
- Per edge, with flush=0:
  - M empty or draining, S empty: M <= input if in_accept, else M.valid <= 0.
  - M empty or draining, S full: M <= S, S.valid <= 0. If in_accept in the same cycle, S <= input.
  - M full and not draining, in_accept: S <= input. in_ready drops the next cycle.
- in_ready register <= ~(next S.valid), taking flush into account.
- Ordering: strict FIFO. S never overtakes M. Nothing is dropped or duplicated.
- Simultaneous S-full, in_valid and out_fire: S moves to M, input moves to S, in_ready stays 0.
- Flush (synchronous, highest priority after reset): M.valid, S.valid <= 0; M.ctrl, S.ctrl <= 0; any input presented that cycle is discarded; in_ready <= 1. Payload data fields may hold stale values; ctrl is always zero when invalid.
- Bubble rule: ctrl_out is 0 whenever out_valid=0, so no MemWrite or RegWrite ever leaks from a bubble.
- Reset asserted mid-transfer clears everything immediately, regardless of clock.
- Data passes through unmodified. No arithmetic on the payload.
- dst=0 never asserts fwd_en.

Decomposition:
- Shared package pipe_pkg holds:
  - CTRL bit indices: REGWRITE=0, MEMTOREG=1, MEMWRITE=2, MEMREAD=3, BRANCH=4, JUMP=5
  - CTRL_W=6
  - the default widths
- Natural sub-module: pipe_skid_buf, a generic 2-entry valid/ready skid of width W. It holds the concatenated payload {ctrl, dst, rdata2, addr, zero, alu}, applies flush and is reusable for the ID/EX and MEM/WB stages. ex_mem_pipe_reg instantiates it and adds the forwarding tap and the ctrl bubble gating.

Test Plan:
1. Reset: rst=1 for 100 ns with random inputs -> all outputs 0, out_valid=0, in_ready=1. Release; hold in_valid=0 -> unchanged.
2. Streaming: out_ready=1; push alu=1234, zero=1, addr=5678, rdata2=4321, dst=10, ctrl=6'b000001, then alu=8765, dst=5 on consecutive cycles -> each appears one cycle later in order, fwd_en=1, fwd_dst=10 then 5, in_ready stays 1.
3. Back-pressure: out_ready=0; push entries A(alu=1), B(alu=2), C(alu=3) -> A held at outputs, B in skid, in_ready=0 from the cycle after B and C not accepted. Raise out_ready -> A, B, C delivered in order with no loss.
4. Flush: M and S full (alu=7, 8), flush=1 with in_valid=1, alu=9 -> next cycle out_valid=0, ctrl_out=0, fwd_en=0, in_ready=1; the value 9 never appears.
5. Forward gating: entry with dst=0 and REGWRITE=1 -> fwd_en=0. Entry with dst=3 and REGWRITE=0 -> fwd_en=0. Entry with dst=3 and REGWRITE=1 -> fwd_en=1, fwd_data=alu_out.
6. Async reset mid-stall: S full, assert rst between clock edges -> outputs zero immediately, before the next edge. Deassert -> in_ready=1 and the stage is empty.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: control-bundle bit map and default stage widths.
package pipe_pkg;
    localparam int PIPE_DATA_W = 32;
    localparam int PIPE_REG_AW = 5;
    localparam int PIPE_CTRL_W = 6;

    localparam int REGWRITE = 0;
    localparam int MEMTOREG = 1;
    localparam int MEMWRITE = 2;
    localparam int MEMREAD  = 3;
    localparam int BRANCH   = 4;
    localparam int JUMP     = 5;
endpackage

// File: rtl/pipe_skid_buf.sv
// Generic 2-entry valid/ready skid register; 1-cycle latency, in_ready registered
// (no combinational path from out_ready), synchronous flush clears both entries.
module pipe_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);
    logic         m_valid, s_valid, s_valid_nxt;
    logic [W-1:0] m_data, s_data;
    logic         in_accept, m_free;

    assign in_accept = in_valid & in_ready;
    assign m_free    = ~m_valid | out_ready;
    assign out_valid = m_valid;
    assign out_data  = m_data;

    // Skid fills only when M is stalled; it empties whenever M can take it.
    always_comb begin
        s_valid_nxt = s_valid;
        if (flush)
            s_valid_nxt = 1'b0;
        else if (m_free)
            s_valid_nxt = s_valid & in_accept;
        else if (in_accept)
            s_valid_nxt = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid  <= 1'b0;
            s_valid  <= 1'b0;
            m_data   <= '0;
            s_data   <= '0;
            in_ready <= 1'b1;
        end else begin
            s_valid  <= s_valid_nxt;
            in_ready <= ~s_valid_nxt;
            if (flush) begin
                // Zeroing the whole entry guarantees the control field is clear too.
                m_valid <= 1'b0;
                m_data  <= '0;
                s_data  <= '0;
            end else if (m_free) begin
                if (s_valid) begin
                    m_valid <= 1'b1;
                    m_data  <= s_data;
                    if (in_accept)
                        s_data <= in_data;
                end else begin
                    m_valid <= in_accept;
                    if (in_accept)
                        m_data <= in_data;
                end
            end else if (in_accept) begin
                s_data <= in_data;
            end
        end
    end
endmodule

// File: rtl/ex_mem_pipe_reg.sv
// EX/MEM pipeline register: skid-buffered payload plus forwarding tap; 1-cycle latency,
// in_ready registered, ctrl forced to zero on bubbles so no write strobe leaks.
module ex_mem_pipe_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = PIPE_DATA_W,
    parameter int REG_AW = PIPE_REG_AW,
    parameter int CTRL_W = PIPE_CTRL_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] alu_in,
    input  logic              zero_in,
    input  logic [DATA_W-1:0] addr_in,
    input  logic [DATA_W-1:0] rdata2_in,
    input  logic [REG_AW-1:0] dst_in,
    input  logic [CTRL_W-1:0] ctrl_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] alu_out,
    output logic              zero_out,
    output logic [DATA_W-1:0] addr_out,
    output logic [DATA_W-1:0] rdata2_out,
    output logic [REG_AW-1:0] dst_out,
    output logic [CTRL_W-1:0] ctrl_out,
    output logic              fwd_en,
    output logic [REG_AW-1:0] fwd_dst,
    output logic [DATA_W-1:0] fwd_data
);
    localparam int PW = CTRL_W + REG_AW + 3 * DATA_W + 1;

    logic [PW-1:0]     in_dat, out_dat;
    logic [CTRL_W-1:0] ctrl_held;

    assign in_dat = {ctrl_in, dst_in, rdata2_in, addr_in, zero_in, alu_in};

    pipe_skid_buf #(.W(PW)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_dat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_dat)
    );

    assign {ctrl_held, dst_out, rdata2_out, addr_out, zero_out, alu_out} = out_dat;

    // A drained entry leaves stale ctrl in M; gate it so bubbles carry no strobes.
    assign ctrl_out = out_valid ? ctrl_held : '0;

    assign fwd_en   = out_valid & ctrl_out[REGWRITE] & (dst_out != '0);
    assign fwd_dst  = dst_out;
    assign fwd_data = alu_out;
endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Directed bench for ex_mem_pipe_reg with a queue-based occupancy model checked every cycle.
module tb_ex_mem_pipe_reg;
    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] alu_in, addr_in, rdata2_in, alu_out, addr_out, rdata2_out, fwd_data;
    logic        zero_in, zero_out, fwd_en;
    logic [4:0]  dst_in, dst_out, fwd_dst;
    logic [5:0]  ctrl_in, ctrl_out;

    int checks = 0;
    int errors = 0;
    int saw9   = 0;

    typedef struct {
        logic [31:0] alu;
        logic        zero;
        logic [31:0] addr;
        logic [31:0] rdata2;
        logic [4:0]  dst;
        logic [5:0]  ctrl;
    } ent_t;

    ent_t q[$];
    ent_t e;
    logic acc;

    always #5 clk = ~clk;

    ex_mem_pipe_reg dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_in(alu_in), .zero_in(zero_in), .addr_in(addr_in),
        .rdata2_in(rdata2_in), .dst_in(dst_in), .ctrl_in(ctrl_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_out(alu_out), .zero_out(zero_out), .addr_out(addr_out),
        .rdata2_out(rdata2_out), .dst_out(dst_out), .ctrl_out(ctrl_out),
        .fwd_en(fwd_en), .fwd_dst(fwd_dst), .fwd_data(fwd_data)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the stage is a FIFO of depth 2; ready means fewer than 2 entries held.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
        end else if (flush) begin
            q.delete();
        end else begin
            acc = in_valid && (q.size() < 2);
            if (q.size() > 0 && out_ready)
                void'(q.pop_front());
            if (acc) begin
                e.alu = alu_in; e.zero = zero_in; e.addr = addr_in;
                e.rdata2 = rdata2_in; e.dst = dst_in; e.ctrl = ctrl_in;
                q.push_back(e);
            end
        end
    end

    always @(negedge clk) begin
        chk("out_valid", out_valid, q.size() > 0);
        chk("in_ready", in_ready, q.size() < 2);
        if (out_valid && alu_out == 32'd9)
            saw9++;
        if (q.size() > 0) begin
            chk("alu_out", alu_out, q[0].alu);
            chk("zero_out", zero_out, q[0].zero);
            chk("addr_out", addr_out, q[0].addr);
            chk("rdata2_out", rdata2_out, q[0].rdata2);
            chk("dst_out", dst_out, q[0].dst);
            chk("ctrl_out", ctrl_out, q[0].ctrl);
            chk("fwd_en", fwd_en, q[0].ctrl[0] && q[0].dst != 0);
            chk("fwd_dst", fwd_dst, q[0].dst);
            chk("fwd_data", fwd_data, q[0].alu);
        end else begin
            chk("ctrl_bubble", ctrl_out, 0);
            chk("fwd_en_bubble", fwd_en, 0);
        end
        if (rst) begin
            chk("rst_alu", alu_out, 0);
            chk("rst_addr", addr_out, 0);
            chk("rst_rdata2", rdata2_out, 0);
            chk("rst_dst_zero", {dst_out, zero_out}, 0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [4:0] d, input logic [5:0] c);
        in_valid = v; alu_in = a; dst_in = d; ctrl_in = c;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 0, 0, 0);
        zero_in = 1'b0; addr_in = 0; rdata2_in = 0;
        // 1. reset with random inputs for 100 ns
        repeat (10) begin
            step();
            in_valid = 1'($urandom); alu_in = $urandom; dst_in = 5'($urandom);
            ctrl_in = 6'($urandom); addr_in = $urandom; rdata2_in = $urandom;
            zero_in = 1'($urandom); out_ready = 1'($urandom); flush = 1'($urandom);
        end
        chk("lit_rst_in_ready", in_ready, 1);
        chk("lit_rst_out_valid", out_valid, 0);
        drive(1'b0, 0, 0, 0); flush = 1'b0; out_ready = 1'b0;
        zero_in = 1'b0; addr_in = 0; rdata2_in = 0;
        rst = 1'b0;
        repeat (3) step();
        chk("lit_idle_out_valid", out_valid, 0);
        chk("lit_idle_alu", alu_out, 0);

        // 2. streaming
        out_ready = 1'b1;
        zero_in = 1'b1; addr_in = 5678; rdata2_in = 4321;
        drive(1'b1, 1234, 10, 6'b000001);
        step();
        chk("lit_s1_alu", alu_out, 1234);
        chk("lit_s1_fwd_dst", fwd_dst, 10);
        chk("lit_s1_fwd_en", fwd_en, 1);
        chk("lit_s1_addr", addr_out, 5678);
        drive(1'b1, 8765, 5, 6'b000001);
        step();
        chk("lit_s2_alu", alu_out, 8765);
        chk("lit_s2_fwd_dst", fwd_dst, 5);
        chk("lit_s2_in_ready", in_ready, 1);
        in_valid = 1'b0;
        step();
        chk("lit_s3_empty", out_valid, 0);

        // 3. back-pressure A, B, C
        out_ready = 1'b0;
        drive(1'b1, 1, 7, 6'b000001); step();
        drive(1'b1, 2, 7, 6'b000001); step();
        chk("lit_bp_in_ready", in_ready, 0);
        drive(1'b1, 3, 7, 6'b000001); step(); step();
        chk("lit_bp_hold_A", alu_out, 1);
        chk("lit_bp_in_ready2", in_ready, 0);
        out_ready = 1'b1; step();
        chk("lit_bp_B", alu_out, 2);
        chk("lit_bp_ready_back", in_ready, 1);
        step();
        in_valid = 1'b0;
        chk("lit_bp_C", alu_out, 3);
        step();
        chk("lit_bp_done", out_valid, 0);

        // 4. flush with both entries full, then with only M full and input accepted
        out_ready = 1'b0;
        drive(1'b1, 7, 3, 6'b000101); step();
        drive(1'b1, 8, 3, 6'b000101); step();
        drive(1'b1, 9, 3, 6'b000101); flush = 1'b1; step();
        flush = 1'b0; in_valid = 1'b0;
        chk("lit_fl_out_valid", out_valid, 0);
        chk("lit_fl_ctrl", ctrl_out, 0);
        chk("lit_fl_fwd_en", fwd_en, 0);
        chk("lit_fl_in_ready", in_ready, 1);
        drive(1'b1, 7, 3, 6'b000101); step();
        drive(1'b1, 9, 3, 6'b000101); flush = 1'b1; step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) step();
        chk("lit_fl_no9", saw9, 0);

        // 5. forwarding gate
        drive(1'b1, 11, 0, 6'b000001); step();
        chk("lit_fwd_dst0", fwd_en, 0);
        drive(1'b1, 12, 3, 6'b000100); step();
        chk("lit_fwd_norw", fwd_en, 0);
        chk("lit_fwd_memwrite", ctrl_out, 6'b000100);
        drive(1'b1, 13, 3, 6'b000001); step();
        chk("lit_fwd_on", fwd_en, 1);
        chk("lit_fwd_data", fwd_data, 13);
        in_valid = 1'b0; step();

        // 6. async reset while stalled with skid full
        out_ready = 1'b0;
        drive(1'b1, 21, 4, 6'b000001); step();
        drive(1'b1, 22, 4, 6'b000001); step();
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("lit_ar_out_valid", out_valid, 0);
        chk("lit_ar_alu", alu_out, 0);
        chk("lit_ar_ctrl", ctrl_out, 0);
        chk("lit_ar_fwd_en", fwd_en, 0);
        chk("lit_ar_in_ready", in_ready, 1);
        step();
        rst = 1'b0;
        step();
        chk("lit_ar_after_ready", in_ready, 1);
        chk("lit_ar_after_valid", out_valid, 0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
